// File: rtl/router3.sv
`default_nettype none
// ============================================================================
//  Module      : router3
//  Description : NoC tile router. Each rx port owns an input FIFO. One
//                round-robin dispatcher looks up one head flit per cycle in
//                an external routing table and moves it into a one-flit
//                holding register on the tx port that the table selects.
//                Flits whose destination index is out of range are discarded.
//  Ports       : clk, reset (sync, active-high)
//                rx_req/rx_ack/rx_data   per-port input handshake + flit
//                tx_req/tx_ack/tx_data   per-port output handshake + flit
//                table_addr/table_data   routing lookup (head flit -> port)
//                drop                    one-cycle pulse per discarded flit
//  Revision    : 1.0  initial release
// ============================================================================
module router3 #(
    parameter int ID         = -1,
    parameter int SIZE       = 8,
    parameter int PORT_COUNT = 5,
    parameter int DEPTH_LOG2 = 2,
    parameter int DIR_BITS   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORT_COUNT-1:0]      rx_req,
    output logic [PORT_COUNT-1:0]      rx_ack,
    input  logic [PORT_COUNT*SIZE-1:0] rx_data,
    output logic [PORT_COUNT-1:0]      tx_req,
    input  logic [PORT_COUNT-1:0]      tx_ack,
    output logic [PORT_COUNT*SIZE-1:0] tx_data,
    output logic [SIZE-1:0]            table_addr,
    input  logic [DIR_BITS-1:0]        table_data,
    output logic                       drop
);

    localparam int                c_DEPTH = 2**DEPTH_LOG2;
    localparam int                c_PW    = $clog2(PORT_COUNT);
    localparam logic [DEPTH_LOG2:0] c_FULL = c_DEPTH[DEPTH_LOG2:0];
    localparam logic [c_PW:0]     c_PC    = PORT_COUNT[c_PW:0];
    localparam logic [DIR_BITS:0] c_PC_D  = PORT_COUNT[DIR_BITS:0];
    localparam logic [c_PW-1:0]   c_LAST  = c_PW'(PORT_COUNT - 1);

    // The router id only tags debug output, so it has no hardware meaning.
    logic w_unused_id;
    assign w_unused_id = (ID < 0);

    logic [SIZE-1:0]       w_head [PORT_COUNT];
    logic [PORT_COUNT-1:0] w_nonempty;
    logic [PORT_COUNT-1:0] w_push;
    logic [PORT_COUNT-1:0] w_pop;
    logic [PORT_COUNT-1:0] w_load;
    logic [PORT_COUNT-1:0] w_tx_busy;

    logic [c_PW-1:0]       r_rr_ptr;
    logic                  r_drop;

    // ------------------------------------------------------------------
    // Per-port input FIFOs
    // ------------------------------------------------------------------
    genvar p;
    generate
        for (p = 0; p < PORT_COUNT; p++) begin : g_port
            logic [SIZE-1:0]       r_mem [c_DEPTH];
            logic [DEPTH_LOG2-1:0] r_wptr;
            logic [DEPTH_LOG2-1:0] r_rptr;
            logic [DEPTH_LOG2:0]   r_count;

            // Ready depends only on registered occupancy: a full FIFO
            // refuses a push even when it pops on the same edge.
            assign rx_ack[p]     = (r_count != c_FULL);
            assign w_push[p]     = rx_req[p] & rx_ack[p];
            assign w_nonempty[p] = (r_count != '0);
            assign w_head[p]     = r_mem[r_rptr];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[p]) r_wptr <= r_wptr + 1'b1;
                    if (w_pop[p])  r_rptr <= r_rptr + 1'b1;
                    case ({w_push[p], w_pop[p]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Storage needs no reset: pointers and count define validity.
            always_ff @(posedge clk) begin
                if (w_push[p]) r_mem[r_wptr] <= rx_data[SIZE*p +: SIZE];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Dispatcher: first non-empty input at or after r_rr_ptr, with wrap
    // ------------------------------------------------------------------
    logic [PORT_COUNT-1:0] w_rot;
    logic                  w_found;
    logic [c_PW-1:0]       w_off;
    logic [c_PW:0]         w_sum;
    logic [c_PW-1:0]       w_sel;
    logic [c_PW-1:0]       w_sel_next;
    logic [SIZE-1:0]       w_sel_head;
    logic                  w_dest_ok;
    logic                  w_dest_busy;
    logic                  w_accept;

    // Rotating the doubled occupancy vector puts r_rr_ptr at bit 0, so the
    // lowest set bit is the distance from the pointer to the winner.
    assign w_rot = PORT_COUNT'({w_nonempty, w_nonempty} >> r_rr_ptr);
    assign w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_sel = (w_sum >= c_PC) ? c_PW'(w_sum - c_PC) : w_sum[c_PW-1:0];
    assign w_sel_next = (w_sel == c_LAST) ? '0 : w_sel + 1'b1;

    always_comb begin
        w_found     = 1'b0;
        w_off       = '0;
        w_sel_head  = '0;
        w_dest_busy = 1'b0;
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = c_PW'(i);
            end
        end
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (w_found && (w_sel == c_PW'(i))) w_sel_head = w_head[i];
            if (table_data == DIR_BITS'(i))     w_dest_busy = w_tx_busy[i];
        end
    end

    assign table_addr = w_sel_head;
    assign w_dest_ok  = ({1'b0, table_data} < c_PC_D);
    // Invalid destinations are consumed (and dropped); valid ones only when
    // their tx slot is empty at this edge.
    assign w_accept   = w_found & (~w_dest_ok | ~w_dest_busy);

    generate
        for (p = 0; p < PORT_COUNT; p++) begin : g_ctl
            assign w_pop[p]  = w_accept & (w_sel == c_PW'(p));
            assign w_load[p] = w_found & w_dest_ok & ~w_tx_busy[p]
                             & (table_data == DIR_BITS'(p));
        end
    endgenerate

    // The pointer advances past the selected input even when it is blocked,
    // so one stalled head never starves the other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_found & ~w_dest_ok;
            if (w_found) r_rr_ptr <= w_sel_next;
        end
    end

    assign drop = r_drop;

    // ------------------------------------------------------------------
    // Per-port tx holding registers
    // ------------------------------------------------------------------
    generate
        for (p = 0; p < PORT_COUNT; p++) begin : g_tx
            logic            r_req;
            logic [SIZE-1:0] r_data;

            // A load only happens into an empty slot, so it never competes
            // with the release below; a freed slot reloads one edge later.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_req  <= 1'b0;
                    r_data <= '0;
                end else if (w_load[p]) begin
                    r_req  <= 1'b1;
                    r_data <= w_sel_head;
                end else if (r_req && tx_ack[p]) begin
                    r_req  <= 1'b0;
                end
            end

            assign w_tx_busy[p]             = r_req;
            assign tx_req[p]                = r_req;
            assign tx_data[SIZE*p +: SIZE]  = r_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_router3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router3
//  Description : Self-checking bench for router3 (5 ports, 8-bit flits,
//                4-deep FIFOs). The routing table maps a flit to
//                destination flit[6:4]; values 5..7 are dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_router3;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rx_req;
    logic [4:0]  rx_ack;
    logic [39:0] rx_data;
    logic [4:0]  tx_req;
    logic [4:0]  tx_ack;
    logic [39:0] tx_data;
    logic [7:0]  table_addr;
    logic [2:0]  table_data;
    logic        drop;

    router3 #(.ID(0), .SIZE(8), .PORT_COUNT(5), .DEPTH_LOG2(2), .DIR_BITS(3)) dut (
        .clk(clk), .reset(reset),
        .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data),
        .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data),
        .table_addr(table_addr), .table_data(table_data), .drop(drop)
    );

    assign table_data = table_addr[6:4];

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {int port; logic [7:0] data;} out_t;
    typedef struct {int src; int dst; logic [7:0] data;} exp_t;
    typedef struct {int src; logic [7:0] data; int dst; bit is_drop;} vec_t;

    out_t olog[$];
    int   act_drops = 0;

    // Observed transfers: sampled at the falling edge, they are the tx
    // handshakes that complete on the following rising edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int q = 0; q < 5; q++) begin
                if (tx_req[q] === 1'b1 && tx_ack[q] === 1'b1)
                    olog.push_back('{q, tx_data[8*q +: 8]});
            end
            if (drop === 1'b1) act_drops++;
        end
    end

    exp_t sbq[$];
    int   rd_idx    = 0;
    int   exp_drops = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event at %0t", nm, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_flit(input int src, input logic [7:0] d);
        int dst;
        dst = int'(d[6:4]);
        if (dst < 5) sbq.push_back('{src, dst, d});
        else         exp_drops++;
    endtask

    // Holds req until the DUT shows ready, then crosses the accept edge.
    task automatic send(input int p, input logic [7:0] d);
        int w;
        w = 0;
        rx_data[8*p +: 8] = d;
        rx_req[p] = 1'b1;
        expect_flit(p, d);
        while (rx_ack[p] !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) fail_now("send_ready");
        step();
    endtask

    task automatic drain();
        while (rd_idx < olog.size()) begin
            out_t o;
            int   hit;
            int   early;
            o   = olog[rd_idx];
            hit = -1;
            for (int k = 0; k < sbq.size(); k++)
                if (hit < 0 && sbq[k].dst == o.port && sbq[k].data == o.data) hit = k;
            n_checks++;
            if (hit < 0) begin
                n_fail++;
                $display("FAIL sb_match: got port %0d flit %0h expected no output", o.port, o.data);
            end else begin
                early = 0;
                for (int k = 0; k < hit; k++)
                    if (sbq[k].src == sbq[hit].src && sbq[k].dst == o.port) early++;
                chk("sb_order", early, 0);
                sbq.delete(hit);
            end
            rd_idx++;
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int w;
        w = 0;
        while (olog.size() < n && w < budget) begin
            step();
            w++;
        end
        if (olog.size() < n) fail_now("wait_out");
    endtask

    vec_t vecs[11];

    initial begin
        int s;

        vecs[0]  = '{4, 8'h21, 2, 1'b0};
        vecs[1]  = '{0, 8'h05, 0, 1'b0};
        vecs[2]  = '{1, 8'h13, 1, 1'b0};
        vecs[3]  = '{2, 8'h3A, 3, 1'b0};
        vecs[4]  = '{3, 8'h4F, 4, 1'b0};
        vecs[5]  = '{4, 8'h70, 7, 1'b1};
        vecs[6]  = '{0, 8'h5C, 5, 1'b1};
        vecs[7]  = '{2, 8'hC2, 4, 1'b0};
        vecs[8]  = '{3, 8'hE1, 6, 1'b1};
        vecs[9]  = '{1, 8'h00, 0, 1'b0};
        vecs[10] = '{4, 8'hFF, 7, 1'b1};

        reset   = 1'b1;
        rx_req  = '0;
        rx_data = '0;
        tx_ack  = 5'h1F;
        repeat (3) step();
        chk("rst_tx_req",  tx_req,  5'h00);
        chk("rst_tx_data", tx_data, 40'h0);
        chk("rst_drop",    drop,    1'b0);
        reset = 1'b0;
        step();
        chk("rst_rx_ack",  rx_ack,  5'h1F);

        // Single-flit vectors: latency, destination decode, drop pulse.
        for (int v = 0; v < 11; v++) begin
            chk("vec_ready", rx_ack[vecs[v].src], 1'b1);
            send(vecs[v].src, vecs[v].data);
            rx_req[vecs[v].src] = 1'b0;
            chk("vec_k_tx_req", tx_req, 5'h00);
            step();
            if (vecs[v].is_drop) begin
                chk("vec_drop",       drop,   1'b1);
                chk("vec_drop_tx",    tx_req, 5'h00);
            end else begin
                chk("vec_tx_req",     tx_req, 5'h01 << vecs[v].dst);
                chk("vec_tx_data",    tx_data[8*vecs[v].dst +: 8], vecs[v].data);
                chk("vec_no_drop",    drop,   1'b0);
            end
            step();
            chk("vec_tx_done", tx_req, 5'h00);
            chk("vec_drop_once", drop, 1'b0);
            drain();
        end

        // Three inputs to one blocked output: round-robin order 0,1,2.
        s = olog.size();
        tx_ack[3] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            rx_data[8*p +: 8] = 8'h30 + 8'(p);
            rx_req[p] = 1'b1;
            expect_flit(p, 8'h30 + 8'(p));
        end
        chk("t2_ready", rx_ack, 5'h1F);
        step();
        rx_req = '0;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("t2_rx_ack", rx_ack, 5'h1F);
        end
        tx_ack[3] = 1'b1;
        wait_out(s + 3, 30);
        if (olog.size() >= s + 3) begin
            chk("t2_first",  olog[s].data,     8'h30);
            chk("t2_second", olog[s + 1].data, 8'h31);
            chk("t2_third",  olog[s + 2].data, 8'h32);
        end
        drain();

        // Backpressure fills the FIFO; nothing lost, order preserved.
        s = olog.size();
        tx_ack[0] = 1'b0;
        for (int i = 1; i <= 5; i++) send(1, 8'(i));
        rx_req[1] = 1'b0;
        chk("t3_full",      rx_ack[1],    1'b0);
        chk("t3_slot",      tx_req,       5'h01);
        chk("t3_slot_data", tx_data[7:0], 8'h01);
        rx_req[1] = 1'bx;
        rx_data[15:8] = 8'hxx;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_still_full", rx_ack[1], 1'b0);
        end
        rx_req[1] = 1'b0;
        rx_data[15:8] = 8'h00;
        tx_ack[0] = 1'b1;
        wait_out(s + 5, 40);
        for (int i = 0; i < 5; i++)
            if (olog.size() > s + i) chk("t3_order", olog[s + i].data, 8'(i + 1));
        chk("t3_ready_again", rx_ack[1], 1'b1);
        drain();

        // A blocked head on port 0 must not hold up port 2.
        tx_ack[1] = 1'b0;
        send(0, 8'h10);
        send(0, 8'h11);
        rx_req[0] = 1'b0;
        s = olog.size();
        send(2, 8'h42);
        rx_req[2] = 1'b0;
        repeat (3) step();
        chk("t4_bypass_cnt", (olog.size() > s), 1'b1);
        if (olog.size() > s) begin
            chk("t4_bypass_port", olog[s].port, 4);
            chk("t4_bypass_data", olog[s].data, 8'h42);
        end
        drain();
        tx_ack[1] = 1'b1;
        wait_out(s + 3, 20);
        drain();

        // Reset while flits are buffered and a slot is full.
        tx_ack[2] = 1'b0;
        for (int i = 0; i < 4; i++) send(3, 8'h20 + 8'(i));
        rx_req[3] = 1'b0;
        chk("t6_slot", tx_req, 5'h04);
        drain();
        reset = 1'b1;
        step();
        chk("t6_tx_req", tx_req, 5'h00);
        chk("t6_rx_ack", rx_ack, 5'h1F);
        chk("t6_drop",   drop,   1'b0);
        sbq.delete();
        reset = 1'b0;
        tx_ack[2] = 1'b1;
        s = olog.size();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_no_tx", tx_req, 5'h00);
        end
        chk("t6_no_stale", olog.size() - s, 0);
        drain();

        chk("drop_count", act_drops, exp_drops);
        chk("sb_empty",   sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
